// File: rtl/frame_config_loader_if.sv
// Purpose: 32-bit bitstream word stream into the configuration loader.
// Latency: none, wires only.
// Backpressure: s_ready from the loader, s_valid/s_data held by the source until accepted.
interface frame_config_loader_if;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/frame_config_loader.sv
// Purpose: hunts sync, parses frame headers, loads one frame of row data and strobes its column.
// Latency: strobe is registered, high in the cycle after the last data word, then one hold cycle.
// Backpressure: s_ready low in STROBE/HOLD only; s_valid low simply freezes state and counters.
module frame_config_loader #(
    parameter int          NumRows         = 8,
    parameter int          NumCols         = 8,
    parameter int          FrameBitsPerRow = 32,
    parameter int          MaxFramesPerCol = 20,
    parameter logic [31:0] SyncWord        = 32'hFAB0FAB1
) (
    input  logic                                CLK,
    input  logic                                resetn,
    frame_config_loader_if.slave                s,
    output logic [NumRows*FrameBitsPerRow-1:0]  FrameData,
    output logic [NumCols*MaxFramesPerCol-1:0]  FrameStrobe,
    output logic                                ConfigBusy,
    output logic                                ConfigDone,
    output logic                                ConfigError
);

    localparam int RW = $clog2(NumRows);
    localparam int SW = NumCols * MaxFramesPerCol;

    typedef enum logic [2:0] {HUNT, HDR, DATA, STROBE, HOLD} state_t;

    state_t         state, state_nxt;
    logic [RW-1:0]  row_cnt;
    logic [7:0]     col_q;
    logic [7:0]     frame_q;

    logic           accept;
    logic           is_sync;
    logic           hdr_end;
    logic           hdr_ok;
    logic           last_row;
    logic [31:0]    strb_idx;
    logic [SW-1:0]  strb_vec;

    assign accept   = s.s_valid & s.s_ready;
    assign is_sync  = (s.s_data == SyncWord);
    assign hdr_end  = s.s_data[31];
    assign hdr_ok   = ({24'd0, s.s_data[23:16]} < 32'(NumCols)) &&
                      ({24'd0, s.s_data[15:8]}  < 32'(MaxFramesPerCol));
    assign last_row = (row_cnt == RW'(NumRows - 1));
    assign strb_idx = 32'(col_q) * 32'(MaxFramesPerCol) + 32'(frame_q);
    assign strb_vec = {{(SW-1){1'b0}}, 1'b1} << strb_idx;

    // State register
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) state <= HUNT;
        else         state <= state_nxt;
    end

    // Next-state: every transition out of HUNT/HDR/DATA waits for an accepted word
    always_comb begin
        state_nxt = state;
        case (state)
            HUNT:    if (accept && is_sync) state_nxt = HDR;
            HDR:     if (accept) state_nxt = (!hdr_end && hdr_ok) ? DATA : HUNT;
            DATA:    if (accept && last_row) state_nxt = STROBE;
            STROBE:  state_nxt = HOLD;
            HOLD:    state_nxt = HDR;
            default: state_nxt = HUNT;
        endcase
    end

    // Outputs decoded from state alone, so s_ready never depends on s_valid
    always_comb begin
        s.s_ready  = (state == HUNT) || (state == HDR) || (state == DATA);
        ConfigBusy = (state != HUNT);
    end

    // Latch target column/frame from a legal header and walk the row counter through DATA
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            row_cnt <= '0;
            col_q   <= '0;
            frame_q <= '0;
        end else if (accept && state == HDR && !hdr_end && hdr_ok) begin
            row_cnt <= '0;
            col_q   <= s.s_data[23:16];
            frame_q <= s.s_data[15:8];
        end else if (accept && state == DATA) begin
            row_cnt <= row_cnt + 1'b1;
        end
    end

    // Row data is only ever written in DATA; it persists across frames and HUNT
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            FrameData <= '0;
        end else if (accept && state == DATA) begin
            FrameData[row_cnt*FrameBitsPerRow +: FrameBitsPerRow] <= s.s_data;
        end
    end

    // One-hot strobe for exactly the cycle spent in STROBE
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) FrameStrobe <= '0;
        else         FrameStrobe <= (accept && state == DATA && last_row) ? strb_vec : '0;
    end

    // Done pulses after an end header; error is sticky until a fresh sync word
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            ConfigDone  <= 1'b0;
            ConfigError <= 1'b0;
        end else begin
            ConfigDone <= accept && (state == HDR) && hdr_end;
            if (accept && state == HUNT && is_sync)
                ConfigError <= 1'b0;
            else if (accept && state == HDR && !hdr_end && !hdr_ok)
                ConfigError <= 1'b1;
        end
    end

endmodule

// File: tb/tb_frame_config_loader.sv
// Purpose: randomized scoreboard bench for frame_config_loader against a word-level parser model.
// Latency: expected strobe/done events are tagged with the cycle after the accepting edge.
// Backpressure: random s_valid gaps; the driver waits on s_ready with a bounded budget.
module tb_frame_config_loader;

    localparam int          NR   = 8;
    localparam int          NC   = 8;
    localparam int          NF   = 20;
    localparam int          FW   = NR * 32;
    localparam int          SW   = NC * NF;
    localparam logic [31:0] SYNC = 32'hFAB0FAB1;

    logic          CLK    = 1'b0;
    logic          resetn = 1'b1;
    logic [FW-1:0] FrameData;
    logic [SW-1:0] FrameStrobe;
    logic          ConfigBusy;
    logic          ConfigDone;
    logic          ConfigError;

    frame_config_loader_if bus ();

    frame_config_loader dut (
        .CLK         (CLK),
        .resetn      (resetn),
        .s           (bus),
        .FrameData   (FrameData),
        .FrameStrobe (FrameStrobe),
        .ConfigBusy  (ConfigBusy),
        .ConfigDone  (ConfigDone),
        .ConfigError (ConfigError)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit            is_done;
        int            idx;
        int            cyc;
        logic [FW-1:0] fd;
    } ev_t;

    ev_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          gap_pct = 0;

    // Reference model: a word-level parser. mode 0 = looking for sync, 1 = expecting header,
    // 2 = collecting rows. Strobe/hold stalls are not modelled; they only show up as timing.
    int          m_mode = 0;
    logic [31:0] m_rows[NR];
    int          m_fill = 0;
    int          m_col  = 0;
    int          m_frame = 0;
    bit          m_err  = 1'b0;

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [FW-1:0] pack_rows();
        logic [FW-1:0] v;
        v = '0;
        for (int r = 0; r < NR; r++) v[r*32 +: 32] = m_rows[r];
        return v;
    endfunction

    task automatic push_event(input bit is_done, input int idx);
        ev_t e;
        e.is_done = is_done;
        e.idx     = idx;
        e.cyc     = cyc + 1;
        e.fd      = pack_rows();
        exp_q.push_back(e);
    endtask

    task automatic model_accept(input logic [31:0] w);
        int col;
        int fr;
        col = int'(w[23:16]);
        fr  = int'(w[15:8]);
        case (m_mode)
            0: if (w == SYNC) begin
                   m_mode = 1;
                   m_err  = 1'b0;
               end
            1: if (w[31]) begin
                   push_event(1'b1, 0);
                   m_mode = 0;
               end else if (col < NC && fr < NF) begin
                   m_col   = col;
                   m_frame = fr;
                   m_fill  = 0;
                   m_mode  = 2;
               end else begin
                   m_err  = 1'b1;
                   m_mode = 0;
               end
            default: begin
                   m_rows[m_fill] = w;
                   m_fill++;
                   if (m_fill == NR) begin
                       push_event(1'b0, m_col * NF + m_frame);
                       m_mode = 1;
                   end
               end
        endcase
    endtask

    function automatic logic [31:0] hdr(input bit e, input int col, input int fr);
        return {e, 7'($urandom), 8'(col), 8'(fr), 8'($urandom)};
    endfunction

    // Call between a posedge and the following negedge; returns #1 after the accepting edge.
    task automatic send_word(input logic [31:0] w);
        bit rdy;
        int n;
        rdy = 1'b0;
        n   = 0;
        if (gap_pct > 0) begin
            for (int g = 0; g < 4; g++) begin
                if ($urandom_range(99) >= gap_pct) break;
                bus.s_valid = 1'b0;
                bus.s_data  = $urandom;
                @(posedge CLK);
                #1;
            end
        end
        bus.s_valid = 1'b1;
        bus.s_data  = w;
        forever begin
            @(negedge CLK);
            rdy = bus.s_ready;
            @(posedge CLK);
            if (rdy) break;
            n++;
            if (n > 50) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: word %h not accepted within %0d cycles", w, n);
                break;
            end
        end
        if (rdy) model_accept(w);
        #1;
        bus.s_valid = 1'b0;
        bus.s_data  = $urandom;
        if (rdy) check("busy_after_word", FW'(ConfigBusy), FW'(m_mode != 0));
    endtask

    task automatic send_frame(input int col, input int fr, input int sync_row);
        send_word(hdr(1'b0, col, fr));
        for (int r = 0; r < NR; r++) send_word((r == sync_row) ? SYNC : 32'($urandom));
    endtask

    // Monitor: per-cycle sanity plus scoreboard pop on any strobe or done
    bit            hold_nxt = 1'b0;
    ev_t           mon_e;
    logic [SW-1:0] oh;
    always @(negedge CLK) begin
        cyc++;
        if (!resetn) begin
            hold_nxt = 1'b0;
        end else begin
            check("config_error", FW'(ConfigError), FW'(m_err));
            check("s_ready", FW'(bus.s_ready), FW'((FrameStrobe == '0) && !hold_nxt));
            if (hold_nxt) check("hold_strobe_zero", FW'(FrameStrobe), '0);
            hold_nxt = (FrameStrobe != '0);
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                mon_e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_event: done=%0d idx=%0d expected at cycle %0d, did not occur",
                         mon_e.is_done, mon_e.idx, mon_e.cyc);
            end
            if (FrameStrobe != '0 || ConfigDone) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: strobe %h done %0d with nothing expected",
                             FrameStrobe, ConfigDone);
                end else begin
                    mon_e = exp_q.pop_front();
                    oh = '0;
                    if (!mon_e.is_done) oh[mon_e.idx] = 1'b1;
                    check("event_cycle", FW'(cyc), FW'(mon_e.cyc));
                    check("strobe_vec", FW'(FrameStrobe), FW'(oh));
                    check("config_done", FW'(ConfigDone), FW'(mon_e.is_done));
                    check("frame_data", FrameData, mon_e.fd);
                    if (mon_e.is_done) check("busy_at_done", FW'(ConfigBusy), '0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        for (int r = 0; r < NR; r++) m_rows[r] = '0;
        #1 resetn = 1'b0;
        repeat (3) @(posedge CLK);
        #2 resetn = 1'b1;

        check("rst_frame_data", FrameData, '0);
        check("rst_strobe", FW'(FrameStrobe), '0);
        check("rst_ready", FW'(bus.s_ready), FW'(1));
        check("rst_busy", FW'(ConfigBusy), '0);
        check("rst_done", FW'(ConfigDone), '0);
        check("rst_error", FW'(ConfigError), '0);

        // Sync hunt: junk discarded, busy only after the sync word
        send_word(32'h12345678);
        send_word(SYNC);

        // Directed frame: col 2, frame 5 -> strobe bit 45, rows A0..A7
        send_word(hdr(1'b0, 2, 5));
        for (int r = 0; r < NR; r++) send_word(32'hA0 + 32'(r));
        repeat (3) @(posedge CLK);
        #1;
        check("frame_a0_rows", FrameData,
              {32'hA7, 32'hA6, 32'hA5, 32'hA4, 32'hA3, 32'hA2, 32'hA1, 32'hA0});

        // End of configuration
        send_word(32'h80000000);

        // Bad header sets sticky error; junk leaves it; next sync clears it
        send_word(SYNC);
        send_word(hdr(1'b0, 8, 0));
        send_word($urandom);
        send_word(SYNC);
        send_word(hdr(1'b0, 0, 20));
        send_word(SYNC);

        // Back-pressure with a sync word as row 3 data
        gap_pct = 40;
        send_frame(7, 19, 3);
        send_frame(int'($urandom_range(NC - 1)), int'($urandom_range(NF - 1)), 3);

        // Reset in the middle of a frame aborts it without a strobe
        gap_pct = 0;
        send_word(hdr(1'b0, 1, 1));
        for (int r = 0; r < 3; r++) send_word($urandom);
        resetn = 1'b0;
        #1;
        check("midrst_frame_data", FrameData, '0);
        check("midrst_strobe", FW'(FrameStrobe), '0);
        check("midrst_ready", FW'(bus.s_ready), FW'(1));
        check("midrst_busy", FW'(ConfigBusy), '0);
        m_mode = 0;
        m_err  = 1'b0;
        for (int r = 0; r < NR; r++) m_rows[r] = '0;
        @(posedge CLK);
        #2 resetn = 1'b1;

        // Random traffic
        gap_pct = 30;
        send_word(SYNC);
        repeat (60) begin
            case ($urandom_range(5))
                0:       send_word($urandom);
                1:       send_word(SYNC);
                2, 3:    send_frame(int'($urandom_range(NC - 1)), int'($urandom_range(NF - 1)),
                                    int'($urandom_range(NR)));
                4:       send_word(hdr(1'b0, int'($urandom_range(15)), int'($urandom_range(31))));
                default: send_word(hdr(1'b1, int'($urandom_range(255)), int'($urandom_range(255))));
            endcase
        end

        repeat (10) @(posedge CLK);
        #1;
        check("queue_drained", FW'(exp_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
